// File: rtl/ofm_write_ctrl_if.sv
// Bus bundle for ofm_write_ctrl: configuration/start, input beat stream and
// DPRAM write-port side. master = producer/controller view, slave = ofm_write_ctrl.
interface ofm_write_ctrl_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int SYSTOLIC_SIZE = 16,
  parameter int ADDR_WIDTH    = 19,
  parameter int CH_WIDTH      = 11
);
  localparam int INOUT_WIDTH = DATA_WIDTH * SYSTOLIC_SIZE;

  // configuration / control
  logic                   start;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [8:0]             ofm_size;
  logic [CH_WIDTH-1:0]    num_ch;
  logic                   upsample_mode;
  logic                   busy;
  logic                   done;
  logic                   cfg_err;

  // input beat stream
  logic                   in_valid;
  logic                   in_ready;
  logic [INOUT_WIDTH-1:0] in_data;

  // DPRAM write port
  logic                   we_b;
  logic [ADDR_WIDTH-1:0]  addr_b;
  logic [INOUT_WIDTH-1:0] din_b;
  logic [4:0]             write_ofm_size;
  logic                   upsample_mode_o;
  logic [8:0]             ofm_size_o;

  modport master (
    output start, base_addr, ofm_size, num_ch, upsample_mode, in_valid, in_data,
    input  in_ready, busy, done, cfg_err,
    input  we_b, addr_b, din_b, write_ofm_size, upsample_mode_o, ofm_size_o
  );

  modport slave (
    input  start, base_addr, ofm_size, num_ch, upsample_mode, in_valid, in_data,
    output in_ready, busy, done, cfg_err,
    output we_b, addr_b, din_b, write_ofm_size, upsample_mode_o, ofm_size_o
  );
endinterface

// File: rtl/ofm_write_ctrl.sv
// OFM write-side address generator/sequencer feeding the feature-map DPRAM port B.
// Optional macro OFM_WRITE_RELU_EN: clamps negative lanes of din_b to zero.
module ofm_write_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int SYSTOLIC_SIZE = 16,
  parameter int INOUT_WIDTH   = DATA_WIDTH * SYSTOLIC_SIZE,
  parameter int ADDR_WIDTH    = 19,
  parameter int CH_WIDTH      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  ofm_write_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // FSM and latched configuration
  logic [1:0]            r_state;
  logic [8:0]            r_size;
  logic [CH_WIDTH-1:0]   r_nch;
  logic                  r_up;
  logic [8:0]            r_w;
  logic [ADDR_WIDTH-1:0] r_plane_step;
  logic [ADDR_WIDTH-1:0] r_row_step;
  logic [ADDR_WIDTH-1:0] r_col_step;
  logic [8:0]            r_last_chunk;
  logic [4:0]            r_last_lanes;
  logic                  r_cfg_err;

  // frame position and incremental address state
  logic [8:0]            r_col;
  logic [8:0]            r_row;
  logic [CH_WIDTH-1:0]   r_ch;
  logic [ADDR_WIDTH-1:0] r_col_off;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_plane_base;

  // output register
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [INOUT_WIDTH-1:0] r_din;
  logic [4:0]             r_wsize;

  // configuration decode, only consumed when start is accepted
  logic                  w_cfg_illegal;
  logic [8:0]            w_cfg_w;
  logic [17:0]           w_cfg_sq;
  logic [ADDR_WIDTH-1:0] w_cfg_row_step;
  logic [ADDR_WIDTH-1:0] w_cfg_col_step;
  logic [8:0]            w_cfg_last_chunk;
  logic [4:0]            w_cfg_last_lanes;
  logic                  w_accept;

  // per-beat datapath
  logic                   w_xfer;
  logic                   w_last_col;
  logic                   w_last_row;
  logic                   w_last_ch;
  logic                   w_last_beat;
  logic [ADDR_WIDTH-1:0]  w_beat_addr;
  logic [ADDR_WIDTH-1:0]  w_next_plane;
  logic [INOUT_WIDTH-1:0] w_din;

  always_comb begin
    w_cfg_illegal    = (bus.ofm_size == 9'd0) || (bus.num_ch == '0) ||
                       (bus.upsample_mode && bus.ofm_size[8]);
    w_cfg_w          = bus.upsample_mode ? {bus.ofm_size[7:0], 1'b0} : bus.ofm_size;
    w_cfg_sq         = w_cfg_w * w_cfg_w;
    w_cfg_row_step   = bus.upsample_mode ? ADDR_WIDTH'({bus.ofm_size, 2'b00})
                                         : ADDR_WIDTH'(bus.ofm_size);
    w_cfg_col_step   = bus.upsample_mode ? ADDR_WIDTH'(2 * SYSTOLIC_SIZE)
                                         : ADDR_WIDTH'(SYSTOLIC_SIZE);
    w_cfg_last_chunk = 9'((bus.ofm_size - 9'd1) / 9'(SYSTOLIC_SIZE));
    w_cfg_last_lanes = ((bus.ofm_size % 9'(SYSTOLIC_SIZE)) == 9'd0)
                       ? 5'(SYSTOLIC_SIZE)
                       : 5'(bus.ofm_size % 9'(SYSTOLIC_SIZE));
    w_accept         = (r_state == IDLE) && bus.start && !w_cfg_illegal;
  end

  always_comb begin
    w_xfer       = bus.in_valid && (r_state == RUN);
    w_last_col   = (r_col == r_last_chunk);
    w_last_row   = (r_row == (r_size - 9'd1));
    w_last_ch    = (r_ch == (r_nch - CH_WIDTH'(1)));
    w_last_beat  = w_last_col && w_last_row && w_last_ch;
    w_beat_addr  = r_row_base + r_col_off;
    w_next_plane = r_plane_base + r_plane_step;
  end

`ifdef OFM_WRITE_RELU_EN
  always_comb begin
    w_din = bus.in_data;
    for (int unsigned i = 0; i < SYSTOLIC_SIZE; i++) begin
      if (bus.in_data[i*DATA_WIDTH + DATA_WIDTH - 1])
        w_din[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
  end
`else
  always_comb begin
    w_din = bus.in_data;
  end
`endif

  // Mode/size outputs are driven from the latched copy so they stay stable
  // across rejected starts and until the next accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_size       <= '0;
      r_nch        <= '0;
      r_up         <= 1'b0;
      r_w          <= '0;
      r_plane_step <= '0;
      r_row_step   <= '0;
      r_col_step   <= '0;
      r_last_chunk <= '0;
      r_last_lanes <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (w_cfg_illegal) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_size       <= bus.ofm_size;
              r_nch        <= bus.num_ch;
              r_up         <= bus.upsample_mode;
              r_w          <= w_cfg_w;
              r_plane_step <= ADDR_WIDTH'(w_cfg_sq);
              r_row_step   <= w_cfg_row_step;
              r_col_step   <= w_cfg_col_step;
              r_last_chunk <= w_cfg_last_chunk;
              r_last_lanes <= w_cfg_last_lanes;
              r_state      <= RUN;
            end
          end
        end
        RUN: begin
          if (w_xfer && w_last_beat)
            r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Address is row_base + col_off; both advance by additions only, and a
  // channel wrap reloads row_base from the freshly advanced plane base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_ch         <= '0;
      r_col_off    <= '0;
      r_row_base   <= '0;
      r_plane_base <= '0;
    end else if (w_accept) begin
      r_col        <= '0;
      r_row        <= '0;
      r_ch         <= '0;
      r_col_off    <= '0;
      r_row_base   <= bus.base_addr;
      r_plane_base <= bus.base_addr;
    end else if (w_xfer) begin
      if (!w_last_col) begin
        r_col     <= r_col + 9'd1;
        r_col_off <= r_col_off + r_col_step;
      end else begin
        r_col     <= '0;
        r_col_off <= '0;
        if (!w_last_row) begin
          r_row      <= r_row + 9'd1;
          r_row_base <= r_row_base + r_row_step;
        end else begin
          r_row <= '0;
          if (!w_last_ch) begin
            r_ch         <= r_ch + CH_WIDTH'(1);
            r_plane_base <= w_next_plane;
            r_row_base   <= w_next_plane;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_wsize <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_addr  <= w_beat_addr;
        r_din   <= w_din;
        r_wsize <= w_last_col ? r_last_lanes : 5'(SYSTOLIC_SIZE);
      end
    end
  end

  assign bus.in_ready        = (r_state == RUN);
  assign bus.busy            = (r_state != IDLE);
  assign bus.done            = (r_state == DONE);
  assign bus.cfg_err         = r_cfg_err;
  assign bus.we_b            = r_we;
  assign bus.addr_b          = r_addr;
  assign bus.din_b           = r_din;
  assign bus.write_ofm_size  = r_wsize;
  assign bus.upsample_mode_o = r_up;
  assign bus.ofm_size_o      = r_w;

endmodule

// File: tb/tb_ofm_write_ctrl.sv
// Directed bench for ofm_write_ctrl: address/size/data model from the frame
// formula, per-cycle compare on the falling edge, plus literal pins.
module tb_ofm_write_ctrl;

  logic clk;
  logic rst_n;

  ofm_write_ctrl_if bus ();

  ofm_write_ctrl #(
    .DATA_WIDTH    (16),
    .SYSTOLIC_SIZE (16),
    .INOUT_WIDTH   (256),
    .ADDR_WIDTH    (19),
    .CH_WIDTH      (11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] addr;
    logic [4:0]  sz;
  } wr_t;

  wr_t          exp_q[$];
  logic [255:0] dat_q[$];
  wr_t          log_q[$];
  logic [255:0] log_d[$];
  wr_t          ref_q[$];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit pend   = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s @%0t", name, $time);
  endtask

  function automatic logic [255:0] model_din(input logic [255:0] d);
    logic [255:0] r;
    r = d;
`ifdef OFM_WRITE_RELU_EN
    for (int i = 0; i < 16; i++)
      if ($signed(d[i*16 +: 16]) < 0) r[i*16 +: 16] = 16'h0000;
`endif
    return r;
  endfunction

  // Per-cycle compare: a write is expected exactly in the cycle after a transfer.
  always @(negedge clk) begin
    wr_t e;
    logic [255:0] d;
    bit popped;
    popped = 1'b0;
    if (chk_en) begin
      chk("we_b", 256'(bus.we_b), 256'(pend));
      if (bus.we_b && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        d = (dat_q.size() > 0) ? dat_q.pop_front() : '0;
        popped = 1'b1;
        chk("addr_b", 256'(bus.addr_b), 256'(e.addr));
        chk("write_ofm_size", 256'(bus.write_ofm_size), 256'(e.sz));
        chk("din_b", bus.din_b, d);
        log_q.push_back('{addr: bus.addr_b, sz: bus.write_ofm_size});
        log_d.push_back(bus.din_b);
      end
      chk("done", 256'(bus.done), 256'(popped && exp_q.size() == 0));
    end
    pend = chk_en && bus.in_valid && bus.in_ready;
    if (pend) dat_q.push_back(model_din(bus.in_data));
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_we_b"}, 256'(bus.we_b), 256'(0));
    chk({tag, "_addr_b"}, 256'(bus.addr_b), 256'(0));
    chk({tag, "_din_b"}, bus.din_b, 256'(0));
    chk({tag, "_wsize"}, 256'(bus.write_ofm_size), 256'(0));
    chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
    chk({tag, "_in_ready"}, 256'(bus.in_ready), 256'(0));
    chk({tag, "_done"}, 256'(bus.done), 256'(0));
    chk({tag, "_cfg_err"}, 256'(bus.cfg_err), 256'(0));
    chk({tag, "_up_o"}, 256'(bus.upsample_mode_o), 256'(0));
    chk({tag, "_size_o"}, 256'(bus.ofm_size_o), 256'(0));
  endtask

  task automatic run_frame(input logic [18:0] base, input int s, input int c,
                           input bit up, input int gap, input int max_beats);
    int w, m, k, total, sent, cyc;
    logic [255:0] d;
    bit v, x;
    wr_t e;
    w = up ? 2 * s : s;
    m = up ? 2 : 1;
    k = (s + 15) / 16;
    exp_q.delete(); dat_q.delete(); log_q.delete(); log_d.delete();
    for (int ch = 0; ch < c; ch++)
      for (int r = 0; r < s; r++)
        for (int cc = 0; cc < k; cc++) begin
          e.addr = 19'(int'(base) + ch * w * w + r * m * w + cc * 16 * m);
          e.sz   = 5'((cc == k - 1) ? s - 16 * (k - 1) : 16);
          exp_q.push_back(e);
        end
    total = exp_q.size();
    chk_en = 1'b1;
    bus.base_addr     = base;
    bus.ofm_size      = 9'(s);
    bus.num_ch        = 11'(c);
    bus.upsample_mode = up;
    bus.start         = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("ofm_size_o", 256'(bus.ofm_size_o), 256'(w));
    chk("upsample_mode_o", 256'(bus.upsample_mode_o), 256'(up));
    chk("busy_run", 256'(bus.busy), 256'(1));
    sent = 0;
    cyc  = 0;
    while (sent < total && sent < max_beats && cyc < 40 * total + 100) begin
      v = ($urandom_range(99) >= gap);
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      if (sent == 0) begin
        d[15:0]  = 16'hFFF0;
        d[31:16] = 16'h0010;
      end
      bus.in_valid = v;
      bus.in_data  = d;
      x = v && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (x) begin
        sent++;
        if (sent == total) chk("in_ready_after_last", 256'(bus.in_ready), 256'(0));
      end
    end
    bus.in_valid = 1'b0;
    if (sent < total && sent < max_beats) fail_now("timeout_waiting_in_ready");
    if (max_beats >= total) begin
      repeat (3) @(posedge clk);
      #1;
      chk("writes_outstanding", 256'(exp_q.size()), 256'(0));
      chk("busy_idle", 256'(bus.busy), 256'(0));
      chk("in_ready_idle", 256'(bus.in_ready), 256'(0));
    end
  endtask

  task automatic illegal_start(input int s, input bit up);
    bus.ofm_size      = 9'(s);
    bus.num_ch        = 11'd1;
    bus.upsample_mode = up;
    bus.start         = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("cfg_err_pulse", 256'(bus.cfg_err), 256'(1));
    chk("cfg_err_busy", 256'(bus.busy), 256'(0));
    chk("cfg_err_in_ready", 256'(bus.in_ready), 256'(0));
    @(posedge clk); #1;
    chk("cfg_err_clear", 256'(bus.cfg_err), 256'(0));
    chk("cfg_err_busy2", 256'(bus.busy), 256'(0));
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.base_addr     = '0;
    bus.ofm_size      = '0;
    bus.num_ch        = '0;
    bus.upsample_mode = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // S=16, C=1, normal
    run_frame(19'd0, 16, 1, 1'b0, 0, 1 << 20);
    chk("t1_count", 256'(log_q.size()), 256'(16));
    if (log_q.size() == 16) begin
      chk("t1_first_addr", 256'(log_q[0].addr), 256'(0));
      chk("t1_last_addr", 256'(log_q[15].addr), 256'(240));
      chk("t1_last_size", 256'(log_q[15].sz), 256'(16));
    end

    // S=26, C=2, normal, base 1000
    run_frame(19'd1000, 26, 2, 1'b0, 0, 1 << 20);
    chk("t2_count", 256'(log_q.size()), 256'(104));
    if (log_q.size() == 104) begin
      chk("t2_addr0", 256'(log_q[0].addr), 256'(1000));
      chk("t2_size0", 256'(log_q[0].sz), 256'(16));
      chk("t2_addr1", 256'(log_q[1].addr), 256'(1016));
      chk("t2_size1", 256'(log_q[1].sz), 256'(10));
      chk("t2_addr2", 256'(log_q[2].addr), 256'(1026));
      chk("t2_plane1", 256'(log_q[52].addr), 256'(1676));
    end
    ref_q = log_q;

    // S=13, C=1, upsample
    run_frame(19'd0, 13, 1, 1'b1, 0, 1 << 20);
    chk("t3_size_o", 256'(bus.ofm_size_o), 256'(26));
    chk("t3_up_o", 256'(bus.upsample_mode_o), 256'(1));
    chk("t3_count", 256'(log_q.size()), 256'(13));
    if (log_q.size() == 13) begin
      chk("t3_addr1", 256'(log_q[1].addr), 256'(52));
      chk("t3_last_addr", 256'(log_q[12].addr), 256'(624));
      chk("t3_last_size", 256'(log_q[12].sz), 256'(13));
    end

    // S=26, C=2 with random valid gaps: same sequence as gap-free run
    run_frame(19'd1000, 26, 2, 1'b0, 40, 1 << 20);
    chk("t4_count", 256'(log_q.size()), 256'(ref_q.size()));
    if (log_q.size() == ref_q.size())
      for (int i = 0; i < ref_q.size(); i++)
        chk("t4_seq", 256'(log_q[i]), 256'(ref_q[i]));

    // illegal configurations
    illegal_start(300, 1'b1);
    illegal_start(0, 1'b0);
    chk("t5_up_o_kept", 256'(bus.upsample_mode_o), 256'(0));

    // reset after 5 beats, then restart
    run_frame(19'd2000, 26, 2, 1'b0, 0, 5);
    #1;
    chk_en = 1'b0;
    pend   = 1'b0;
    exp_q.delete(); dat_q.delete();
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(19'd2000, 26, 2, 1'b0, 0, 1 << 20);
    chk("t6_count", 256'(log_q.size()), 256'(104));
    if (log_q.size() > 0) begin
      chk("t6_restart_addr", 256'(log_q[0].addr), 256'(2000));
`ifdef OFM_WRITE_RELU_EN
      chk("t6_relu_neg", 256'(log_d[0][15:0]), 256'(16'h0000));
`else
      chk("t6_lane0_raw", 256'(log_d[0][15:0]), 256'(16'hFFF0));
`endif
      chk("t6_lane1", 256'(log_d[0][31:16]), 256'(16'h0010));
    end

    chk_en = 1'b0;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout @%0t", $time);
    $fatal(1);
  end

endmodule
